// File: rtl/string_eval_pkg.sv
// string_eval_pkg
//   Shared types and constants for the streaming ASCII expression evaluator.
//   state_t       : evaluator FSM states
//   char_class_t  : classification of one input character
//   ASCII_*       : character codes the classifier and FSM compare against
package string_eval_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_NUM   = 2'd1,
      ST_OP    = 2'd2,
      ST_ERR   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      CLS_DIGIT = 2'd0,
      CLS_OP    = 2'd1,
      CLS_SPACE = 2'd2,
      CLS_OTHER = 2'd3
   } char_class_t;

   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_9     = 8'h39;
   localparam logic [7:0] ASCII_PLUS  = 8'h2B;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_STAR  = 8'h2A;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

endpackage

// File: rtl/string_eval_ascii_class.sv
// ascii_class
//   Purely combinational character classifier.
//   char_i  [7:0] : ASCII character
//   class_o       : digit / op / space / other
//   digit_o [3:0] : numeric value of a digit, 0 for any other class
module ascii_class
   import string_eval_pkg::*;
(
   input  logic [7:0]  char_i,
   output char_class_t class_o,
   output logic [3:0]  digit_o
);

   // Map the character to its class; '0'..'9' are 8'h30..8'h39 so the low nibble is the value
   always_comb begin
      class_o = CLS_OTHER;
      digit_o = 4'd0;
      if ((char_i >= ASCII_0) && (char_i <= ASCII_9)) begin
         class_o = CLS_DIGIT;
         digit_o = char_i[3:0];
      end else if ((char_i == ASCII_PLUS) || (char_i == ASCII_MINUS) || (char_i == ASCII_STAR)) begin
         class_o = CLS_OP;
      end else if (char_i == ASCII_SPACE) begin
         class_o = CLS_SPACE;
      end else begin
         class_o = CLS_OTHER;
      end
   end

endmodule

// File: rtl/string_eval.sv
// string_eval
//   Evaluates a stream of ASCII characters as an integer expression with
//   '+', '-', '*' (with '*' binding tighter), one character per clock.
//   clk         : clock, rising edge
//   clr         : asynchronous active-high reset
//   in    [7:0] : ASCII character sampled every rising edge
//   out         : characters so far form a well-formed expression
//   value [W-1:0]: current expression value (meaningful when out=1)
//   err         : sticky syntax error
module string_eval
   import string_eval_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int MAX_DIGITS = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [7:0]       in,
   output logic             out,
   output logic [WIDTH-1:0] value,
   output logic             err
);

   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

   char_class_t      cls_s;
   logic [3:0]       digit_s;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0] cur_q, cur_d;
   logic             neg_q, neg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic             out_q, err_q;

   logic [WIDTH-1:0] term_s;
   logic [WIDTH-1:0] cur_digit_s;
   logic [WIDTH-1:0] final_term_s;

   ascii_class u_class (
      .char_i  (in),
      .class_o (cls_s),
      .digit_o (digit_s)
   );

   // Completed value of the current term, and the operand extended by one more digit
   assign term_s      = prod_q * cur_q;
   assign cur_digit_s = (cur_q << 3) + (cur_q << 1) + {{(WIDTH-4){1'b0}}, digit_s};

   // Next-state and datapath update for the character on this edge
   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      prod_d  = prod_q;
      cur_d   = cur_q;
      neg_d   = neg_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_EMPTY, ST_OP: begin
            case (cls_s)
               CLS_DIGIT: begin
                  state_d = ST_NUM;
                  cur_d   = cur_digit_s;
                  cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
               end
               CLS_SPACE: state_d = state_q;
               default:   state_d = ST_ERR;
            endcase
         end
         ST_NUM: begin
            case (cls_s)
               CLS_DIGIT: begin
                  // Operand already full: an extra digit is a syntax error, datapath frozen
                  if (cnt_q == CW'(MAX_DIGITS)) begin
                     state_d = ST_ERR;
                  end else begin
                     cur_d = cur_digit_s;
                     cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                  end
               end
               CLS_OP: begin
                  state_d = ST_OP;
                  cur_d   = ZERO_W;
                  cnt_d   = {CW{1'b0}};
                  if (in == ASCII_STAR) begin
                     prod_d = term_s;
                  end else begin
                     // Fold the finished term into sum with the sign it was started under
                     sum_d  = neg_q ? (sum_q - term_s) : (sum_q + term_s);
                     prod_d = ONE_W;
                     neg_d  = (in == ASCII_MINUS);
                  end
               end
               CLS_SPACE: state_d = state_q;
               default:   state_d = ST_ERR;
            endcase
         end
         ST_ERR:  state_d = ST_ERR;
         default: state_d = ST_ERR;
      endcase
   end

   // Value as if the expression ended now; only published when landing in NUM
   assign final_term_s = prod_d * cur_d;

   // Result register input
   always_comb begin
      value_d = value_q;
      if (state_d == ST_NUM) begin
         value_d = neg_d ? (sum_d - final_term_s) : (sum_d + final_term_s);
      end else begin
         value_d = value_q;
      end
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= ST_EMPTY;
         sum_q   <= ZERO_W;
         prod_q  <= ONE_W;
         cur_q   <= ZERO_W;
         neg_q   <= 1'b0;
         cnt_q   <= {CW{1'b0}};
         value_q <= ZERO_W;
         out_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         prod_q  <= prod_d;
         cur_q   <= cur_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
         value_q <= value_d;
         out_q   <= (state_d == ST_NUM);
         err_q   <= (state_d == ST_ERR);
      end
   end

   assign out   = out_q;
   assign err   = err_q;
   assign value = value_q;

endmodule
